// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Shares one C2 main-memory bus between two line-level requesters
//   (e.g. D-cache = 0, I-cache = 1). Round-robin arbitration, a single
//   outstanding READ/WRITE command, RESPONSE wait with timeout, and a
//   one-cycle completion pulse back to the owning requester.
//
// Ports
//   clk, reset_n        clock, synchronous active-low reset
//   req_valid/write     per-requester request and direction (bit i = req i)
//   req_addr/wdata      per-requester line address / write line (packed)
//   req_ready           one-hot accept pulse (combinational, IDLE only)
//   rsp_valid           one-hot completion pulse to the owner
//   rsp_err             completion was a timeout
//   rsp_rdata           read line (0 for writes and timeouts)
//   mem_cmd             C2 command: 0 NOP, 2 READ, 3 WRITE
//   mem_addr/wdata      command address / write line
//   mem_rsp/rdata       memory status (1 = RESPONSE) and read line
//   spurious            sticky flag: RESPONSE seen outside WAIT
module mem_bus_arbiter #(
  parameter int ADDR_W     = 15,
  parameter int LINE_BYTES = 16,
  parameter int TIMEOUT    = 100
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [1:0]                   req_valid,
  input  logic [1:0]                   req_write,
  input  logic [2*ADDR_W-1:0]          req_addr,
  input  logic [2*LINE_BYTES*8-1:0]    req_wdata,
  output logic [1:0]                   req_ready,
  output logic [1:0]                   rsp_valid,
  output logic                         rsp_err,
  output logic [LINE_BYTES*8-1:0]      rsp_rdata,
  output logic [1:0]                   mem_cmd,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic [LINE_BYTES*8-1:0]      mem_wdata,
  input  logic [1:0]                   mem_rsp,
  input  logic [LINE_BYTES*8-1:0]      mem_rdata,
  output logic                         spurious
);

  localparam int LW    = LINE_BYTES * 8;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t r_state, w_next;

  logic             r_last;
  logic             r_owner;
  logic             r_write;
  logic [ADDR_W-1:0] r_addr;
  logic [LW-1:0]    r_wdata;
  logic [CNT_W-1:0] r_cnt;
  logic [LW-1:0]    r_rdata;
  logic             r_err;
  logic             r_spur;

  logic             w_any;
  logic             w_gnt;
  logic             w_take;
  logic             w_rsp_hit;
  logic             w_timeout;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [LW-1:0]    w_sel_wdata;

  assign w_any     = |req_valid;
  assign w_rsp_hit = (mem_rsp == 2'd1);
  assign w_timeout = (r_cnt == CNT_LAST);
  // Gated by reset_n so no accept pulse is shown while reset is applied.
  assign w_take    = (r_state == S_IDLE) && w_any && reset_n;

  // Round-robin pick: a lone requester wins; on a tie the one not granted last.
  always_comb begin
    w_gnt = 1'b0;
    case (req_valid)
      2'b01:   w_gnt = 1'b0;
      2'b10:   w_gnt = 1'b1;
      2'b11:   w_gnt = ~r_last;
      default: w_gnt = 1'b0;
    endcase
  end

  assign w_sel_addr  = w_gnt ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
  assign w_sel_wdata = w_gnt ? req_wdata[2*LW-1:LW]        : req_wdata[LW-1:0];

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_any) w_next = S_ISSUE;
      S_ISSUE: w_next = S_WAIT;
      S_WAIT:  if (w_rsp_hit || w_timeout) w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Transaction latches, wait counter and sticky spurious flag
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_last  <= 1'b1;
      r_owner <= 1'b0;
      r_write <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_cnt   <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
      r_spur  <= 1'b0;
    end else begin
      if (w_rsp_hit && (r_state != S_WAIT)) r_spur <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_last  <= w_gnt;
            r_owner <= w_gnt;
            r_write <= req_write[w_gnt];
            r_addr  <= w_sel_addr;
            r_wdata <= w_sel_wdata;
          end
        end
        S_ISSUE: r_cnt <= '0;
        S_WAIT: begin
          // A response on the final timeout cycle still counts as success.
          if (w_rsp_hit) begin
            r_rdata <= r_write ? '0 : mem_rdata;
            r_err   <= 1'b0;
          end else if (w_timeout) begin
            r_rdata <= '0;
            r_err   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Output logic
  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    rsp_err   = 1'b0;
    rsp_rdata = '0;
    mem_cmd   = 2'd0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (w_take) req_ready[w_gnt] = 1'b1;
    case (r_state)
      S_ISSUE: begin
        mem_cmd   = r_write ? 2'd3 : 2'd2;
        mem_addr  = r_addr;
        mem_wdata = r_wdata;
      end
      S_WAIT: begin
        mem_addr  = r_addr;
        mem_wdata = r_wdata;
      end
      S_RESP: begin
        rsp_valid[r_owner] = 1'b1;
        rsp_err            = r_err;
        rsp_rdata          = r_rdata;
      end
      default: ;
    endcase
  end

  assign spurious = r_spur;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;

  localparam int AW = 15;
  localparam int LB = 16;
  localparam int LW = LB * 8;
  localparam int TO = 8;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [1:0]        req_valid;
  logic [1:0]        req_write;
  logic [AW-1:0]     ta [2];
  logic [LW-1:0]     tw [2];
  logic [2*AW-1:0]   req_addr;
  logic [2*LW-1:0]   req_wdata;
  logic [1:0]        req_ready;
  logic [1:0]        rsp_valid;
  logic              rsp_err;
  logic [LW-1:0]     rsp_rdata;
  logic [1:0]        mem_cmd;
  logic [AW-1:0]     mem_addr;
  logic [LW-1:0]     mem_wdata;
  logic [1:0]        mem_rsp;
  logic [LW-1:0]     mem_rdata;
  logic              spurious;

  assign req_addr  = {ta[1], ta[0]};
  assign req_wdata = {tw[1], tw[0]};

  always #5 clk = ~clk;

  mem_bus_arbiter #(
    .ADDR_W     (AW),
    .LINE_BYTES (LB),
    .TIMEOUT    (TO)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_err   (rsp_err),
    .rsp_rdata (rsp_rdata),
    .mem_cmd   (mem_cmd),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rsp   (mem_rsp),
    .mem_rdata (mem_rdata),
    .spurious  (spurious)
  );

  int checks = 0;
  int errors = 0;
  int last_g;              // reference model: last granted requester
  logic [LW-1:0] pat_line;

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  function automatic logic [LW-1:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic new_req(input int i);
    req_write[i] = 1'($urandom_range(0, 1));
    ta[i]        = AW'($urandom);
    tw[i]        = rand_line();
  endtask

  // Serve one transaction starting in an IDLE cycle with requests presented.
  // k = cycle (after ISSUE) at which memory answers; k > TO means silent.
  task automatic serve(input int k, input bit drop, input bit fix, input logic [LW-1:0] fline);
    int            g;
    int            nwait;
    logic [1:0]    oh;
    logic          w;
    logic [AW-1:0] a;
    logic [LW-1:0] d;
    logic [LW-1:0] exp_rd;
    logic          err;
    int unsigned   r;
    settle();
    if (req_valid == 2'b01)      g = 0;
    else if (req_valid == 2'b10) g = 1;
    else                         g = 1 - last_g;
    oh = (g == 0) ? 2'b01 : 2'b10;
    chk("grant", LW'(req_ready), LW'(oh));
    last_g = g;
    w = req_write[g];
    a = ta[g];
    d = tw[g];
    tick();
    if (drop) req_valid[g] = 1'b0;
    else      new_req(g);
    settle();
    chk("issue_cmd",   LW'(mem_cmd),   w ? LW'(3) : LW'(2));
    chk("issue_addr",  LW'(mem_addr),  LW'(a));
    chk("issue_wdata", mem_wdata,      d);
    chk("issue_ready", LW'(req_ready), '0);
    nwait  = (k <= TO) ? k : TO;
    err    = (k > TO);
    exp_rd = '0;
    for (int j = 1; j <= nwait; j++) begin
      tick();
      mem_rdata = rand_line();
      if (j == k) begin
        mem_rsp = 2'd1;
        if (fix) mem_rdata = fline;
        if (!w) exp_rd = mem_rdata;
      end else begin
        r = $urandom_range(0, 2);
        mem_rsp = (r == 0) ? 2'd0 : ((r == 1) ? 2'd2 : 2'd3);
      end
      settle();
      chk("wait_cmd",   LW'(mem_cmd),   '0);
      chk("wait_addr",  LW'(mem_addr),  LW'(a));
      chk("wait_valid", LW'(rsp_valid), '0);
      chk("wait_ready", LW'(req_ready), '0);
    end
    tick();
    mem_rsp   = 2'd0;
    mem_rdata = rand_line();
    settle();
    chk("rsp_valid", LW'(rsp_valid), LW'(oh));
    chk("rsp_err",   LW'(rsp_err),   LW'(err));
    chk("rsp_rdata", rsp_rdata,      exp_rd);
    chk("rsp_cmd",   LW'(mem_cmd),   '0);
    chk("rsp_ready", LW'(req_ready), '0);
    tick();
    chk("idle_valid", LW'(rsp_valid), '0);
  endtask

  initial begin
    reset_n   = 1'b0;
    req_valid = 2'b00;
    req_write = 2'b00;
    ta[0] = '0; ta[1] = '0;
    tw[0] = '0; tw[1] = '0;
    mem_rsp   = 2'd0;
    mem_rdata = '0;
    last_g    = 1;
    for (int i = 0; i < LB; i++) pat_line[8*i +: 8] = 8'(i);

    // Reset state
    tick(); tick();
    settle();
    chk("rst_ready", LW'(req_ready), '0);
    chk("rst_valid", LW'(rsp_valid), '0);
    chk("rst_err",   LW'(rsp_err),   '0);
    chk("rst_rdata", rsp_rdata,      '0);
    chk("rst_cmd",   LW'(mem_cmd),   '0);
    chk("rst_addr",  LW'(mem_addr),  '0);
    chk("rst_wdata", mem_wdata,      '0);
    chk("rst_spur",  LW'(spurious),  '0);
    reset_n = 1'b1;
    tick();

    // Contention from reset: expect 0,1,0,1 with strict alternation
    new_req(0); new_req(1);
    req_valid = 2'b11;
    for (int n = 0; n < 4; n++) begin
      serve(int'($urandom_range(1, 4)), 1'b0, 1'b0, '0);
      chk("alt_order", LW'(last_g), LW'(n % 2));
    end
    req_valid = 2'b00;
    tick();

    // Single read, response 3 cycles after ISSUE, fixed line 0x0F0E..00
    req_write[0] = 1'b0;
    ta[0] = 15'h0123;
    req_valid = 2'b01;
    serve(3, 1'b1, 1'b1, pat_line);

    // Write from requester 1
    req_write[1] = 1'b1;
    ta[1] = 15'h7FFF;
    tw[1] = {LB{8'hAA}};
    req_valid = 2'b10;
    serve(2, 1'b1, 1'b1, pat_line);
    settle();
    chk("spur_clear", LW'(spurious), '0);

    // Timeout (memory silent), then normal service, then response on last cycle
    new_req(0); req_write[0] = 1'b0; req_valid = 2'b01;
    serve(TO + 5, 1'b1, 1'b0, '0);
    new_req(1); req_write[1] = 1'b0; req_valid = 2'b10;
    serve(1, 1'b1, 1'b0, '0);
    new_req(0); req_write[0] = 1'b0; req_valid = 2'b01;
    serve(TO, 1'b1, 1'b0, '0);

    // Spurious response while IDLE
    req_valid = 2'b00;
    mem_rsp   = 2'd1;
    mem_rdata = rand_line();
    settle();
    chk("spur_nready", LW'(req_ready), '0);
    tick();
    mem_rsp = 2'd0;
    settle();
    chk("spur_set",    LW'(spurious),  LW'(1));
    chk("spur_nvalid", LW'(rsp_valid), '0);
    tick(); tick(); tick();
    chk("spur_sticky", LW'(spurious),  LW'(1));
    chk("spur_nvalid2", LW'(rsp_valid), '0);

    // Reset during WAIT
    new_req(0); req_valid = 2'b01;
    settle();
    chk("rw_grant", LW'(req_ready), LW'(2'b01));
    last_g = 0;
    tick();
    req_valid = 2'b00;
    tick(); tick();
    reset_n = 1'b0;
    tick();
    settle();
    chk("rw_cmd",   LW'(mem_cmd),   '0);
    chk("rw_valid", LW'(rsp_valid), '0);
    chk("rw_spur",  LW'(spurious),  '0);
    reset_n = 1'b1;
    last_g  = 1;
    for (int n = 0; n < TO + 3; n++) begin
      tick();
      chk("rw_quiet", LW'(rsp_valid), '0);
    end
    new_req(0); new_req(1); req_valid = 2'b11;
    serve(2, 1'b1, 1'b0, '0);
    chk("rw_first", LW'(last_g), '0);
    serve(1, 1'b1, 1'b0, '0);

    // Randomized traffic
    for (int n = 0; n < 60; n++) begin
      for (int i = 0; i < 2; i++) begin
        if (!req_valid[i] && ($urandom_range(0, 1) == 1)) begin
          new_req(i);
          req_valid[i] = 1'b1;
        end
      end
      if (req_valid == 2'b00) begin
        settle();
        chk("rnd_idle_ready", LW'(req_ready), '0);
        tick();
      end else begin
        serve(int'($urandom_range(1, TO + 2)), ($urandom_range(0, 2) != 0), 1'b0, '0);
      end
    end
    settle();
    chk("rnd_spur", LW'(spurious), '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single C2 main-memory bus (line-granular READ/WRITE, RESPONSE handshake) between two line-level requesters, e.g. the data cache and the instruction cache.
- Arbitrates round-robin and issues one C2 command at a time.
- Waits for the memory RESPONSE, then returns read data or write completion to the owning requester.
- Enforces a response timeout.

Parameters:
- ADDR_W, 15, line address width (19-bit byte address minus 4-bit offset).
- LINE_BYTES, 16, bytes per cache line transferred per command.
- TIMEOUT, 100, max cycles in WAIT before the transaction is aborted with error (≥1).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous reset, active-low.
- req_valid  in  2  per-requester request pending; bit i = requester i.
- req_write  in  2  per-requester 1=WRITE, 0=READ.
- req_addr  in  2*ADDR_W  per-requester line address, requester i at [i*ADDR_W +: ADDR_W].
- req_wdata  in  2*LINE_BYTES*8  per-requester write line.
- req_ready  out  2  one-hot accept pulse; request latched this cycle.
- rsp_valid  out  2  one-hot completion pulse to the owner.
- rsp_err  out  1  qualifies rsp_valid; 1 = timed out.
- rsp_rdata  out  LINE_BYTES*8  read line; valid with rsp_valid on a read.
- mem_cmd  out  2  C2 command: 0 NOP, 2 READ, 3 WRITE.
- mem_addr  out  ADDR_W  line address for mem_cmd.
- mem_wdata  out  LINE_BYTES*8  write line.
- mem_rsp  in  2  memory status: 1 = RESPONSE, others ignored.
- mem_rdata  in  LINE_BYTES*8  read line, valid when mem_rsp==1.
- spurious  out  1  sticky: RESPONSE seen outside WAIT.

Behaviour:
- Reset (reset_n=0 at posedge):
  - state=IDLE, last_grant=1 (requester 0 wins first tie).
  - All outputs 0; mem_cmd=NOP; wait counter=0; spurious=0.
- Reset mid-transaction aborts immediately:
  - No rsp_valid is produced.
  - mem_cmd returns to NOP the cycle after reset is sampled.
- States:
  - IDLE: if any req_valid, grant and assert req_ready[g] combinationally this cycle.
    - Latch write, addr and wdata of g, then go to ISSUE.
    - Single requester: grant it. Both requesting: g = ~last_grant.
    - last_grant<=g on grant.
  - ISSUE: drive mem_cmd=READ/WRITE, mem_addr and mem_wdata from latches for exactly one cycle. Counter<=0; go to WAIT.
  - WAIT: mem_cmd=NOP; mem_addr and mem_wdata hold their latched values.
    - mem_rsp==1: latch mem_rdata (reads only; writes latch 0), err<=0, go to RESP.
    - Otherwise counter++. When counter==TIMEOUT-1 and no response: rdata<=0, err<=1, go to RESP.
    - A response coinciding with the timeout cycle counts as success.
  - RESP: rsp_valid[g]=1 for one cycle with rsp_err and rsp_rdata; go to IDLE.
- Outside RESP, rsp_valid=0, rsp_err=0 and rsp_rdata=0.
- Latency (response sampled k cycles after ISSUE, k≥1):
  - req_ready at T, ISSUE at T+1, rsp_valid at T+1+k+1.
  - Next grant no earlier than T+3+k.
- Requesters must hold request fields stable while req_valid=1 and req_ready=0. Dropping req_valid before grant is legal; that request is not served.
- req_ready is never asserted outside IDLE. At most one outstanding transaction.
- mem_rsp==1 in IDLE, ISSUE or RESP is ignored for data and sets spurious (cleared only by reset).
- No starvation: with both requesters continuously valid, grants strictly alternate.

Test Plan:
- Single read: req0 addr=0x0123, memory responds 3 cycles after ISSUE with line 0x00..0F → mem_cmd=2 for one cycle with mem_addr=0x0123; rsp_valid=01 at T+5 with rsp_rdata=0x0F0E..00 and rsp_err=0.
- Write: req1 write addr=0x7FFF, wdata all 0xAA → mem_cmd=3 with mem_wdata=0xAA..AA; after RESPONSE, rsp_valid=10 with rsp_rdata=0.
- Contention: both valid continuously for 4 transactions from reset → grant order 0,1,0,1; req_ready is never 11.
- Timeout: TIMEOUT=8, memory silent → exactly 8 WAIT cycles, then rsp_valid with rsp_err=1 and rsp_rdata=0; next request is served normally.
- Spurious: mem_rsp=1 while IDLE → spurious=1 and stays 1; no rsp_valid.
- Reset during WAIT → no rsp_valid, mem_cmd=0, state IDLE; requester 0 wins the next simultaneous request.
